// File: rtl/float_divider.sv
// float_divider: sequential floating-point divider (restoring mantissa divide, RNE rounding).
// Define FLOAT_DIVIDER_STATUS_EN to add the flags output {invalid, div_by_zero, overflow, underflow, inexact}.
module float_divider #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         start,
  output logic [W-1:0] y,
  output logic         is_output_valid,
  output logic         busy
`ifdef FLOAT_DIVIDER_STATUS_EN
  ,
  output logic [4:0]   flags
`endif
);
  localparam int DIV_STEPS = MAN_WIDTH + 3;
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EXP_WIDTH-1:0] EMAX = '1;
  localparam logic [W-1:0] NAN = {1'b0, EMAX, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, DIVIDE, NORMALIZE, ROUND, DONE} state_t;
  state_t state, next;

  logic [W-1:0] ra, rb, spec_y;
  logic sign, special, guard, sticky;
  logic [XW-1:0] exp;
  logic [MAN_WIDTH+1:0] rem;
  logic [MAN_WIDTH:0] div, man;
  logic [DIV_STEPS-1:0] q;
  logic [CW-1:0] cnt;

  logic sa, sb, s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_res, inf_res, spec;
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [MAN_WIDTH-1:0] fa, fb;
  logic [W-1:0] spec_val;
  logic ge;
  logic [MAN_WIDTH+1:0] rem_next;
  logic [DIV_STEPS-1:0] nq;
  logic [XW-1:0] ne, re;
  logic inc, carry, ovf, unf;
  logic [MAN_WIDTH+1:0] mr;
  logic [MAN_WIDTH:0] mf;
  logic [W-1:0] y_next;

  always_comb begin
    {sa, ea, fa} = ra;
    {sb, eb, fb} = rb;
    s = sa ^ sb;
    a_zero = ea == '0;
    b_zero = eb == '0;
    a_inf = ea == EMAX && fa == '0;
    b_inf = eb == EMAX && fb == '0;
    a_nan = ea == EMAX && fa != '0;
    b_nan = eb == EMAX && fb != '0;
    nan_res = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    // once NaN is excluded, x/0 and inf/x are the only infinite outcomes; the rest are zero
    inf_res = b_zero | a_inf;
    spec = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    spec_val = nan_res ? NAN : inf_res ? {s, EMAX, {MAN_WIDTH{1'b0}}} : {s, {(W-1){1'b0}}};
    ge = rem >= {1'b0, div};
    rem_next = (ge ? rem - {1'b0, div} : rem) << 1;
    nq = q[DIV_STEPS-1] ? q : q << 1;
    ne = q[DIV_STEPS-1] ? exp : exp - 1'b1;
    inc = guard & (sticky | man[0]);
    mr = {1'b0, man} + {{(MAN_WIDTH+1){1'b0}}, inc};
    carry = mr[MAN_WIDTH+1];
    mf = carry ? mr[MAN_WIDTH+1:1] : mr[MAN_WIDTH:0];
    re = exp + {{(XW-1){1'b0}}, carry};
    ovf = !re[XW-1] && re >= {2'b00, EMAX};
    unf = re[XW-1] || re == '0;
    y_next = special ? spec_y : ovf ? {sign, EMAX, {MAN_WIDTH{1'b0}}} :
             unf ? {sign, {(W-1){1'b0}}} : {sign, re[EXP_WIDTH-1:0], mf[MAN_WIDTH-1:0]};
  end

  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? SETUP : state;
      SETUP:      next = spec ? ROUND : DIVIDE;
      DIVIDE:     next = cnt == CW'(DIV_STEPS - 1) ? NORMALIZE : DIVIDE;
      NORMALIZE:  next = ROUND;
      ROUND:      next = DONE;
      default:    next = IDLE;
    endcase
  end

  assign busy = state == SETUP || state == DIVIDE || state == NORMALIZE || state == ROUND;

`ifdef FLOAT_DIVIDER_STATUS_EN
  logic [4:0] spec_flags;
  always_ff @(posedge clock)
    if (reset) begin
      flags <= '0;
      spec_flags <= '0;
    end else if (state == SETUP) spec_flags <= {nan_res, b_zero & ~nan_res, 3'b000};
    else if (state == ROUND)
      flags <= special ? spec_flags : {2'b00, ovf, unf, guard | sticky | ovf | unf};
`endif

  always_ff @(posedge clock)
    if (reset) begin
      {ra, rb, spec_y, y} <= '0;
      {sign, special, guard, sticky, is_output_valid} <= '0;
      {exp, rem, div, man, q, cnt} <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            ra <= a;
            rb <= b;
            is_output_valid <= 1'b0;
          end
        SETUP: begin
          sign <= s;
          special <= spec;
          spec_y <= spec_val;
          exp <= {2'b00, ea} - {2'b00, eb} + BIAS_X;
          rem <= {2'b01, fa};
          div <= {1'b1, fb};
          q <= '0;
          cnt <= '0;
        end
        DIVIDE: begin
          rem <= rem_next;
          q <= {q[DIV_STEPS-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        NORMALIZE: begin
          man <= nq[DIV_STEPS-1:2];
          guard <= nq[1];
          sticky <= nq[0] | (|rem);
          exp <= ne;
        end
        ROUND: begin
          y <= y_next;
          is_output_valid <= 1'b1;
        end
        default: ;
      endcase
endmodule
